// File: rtl/md5_guess_generator.sv
// ----------------------------------------------------------------------------
// md5_guess_generator
//
// Brute-force candidate source feeding MD5Pipeline. Walks every string over
// the contiguous character range [CHARSET_LO, CHARSET_HI], starting at length
// start_len+1 and ending after the last string of length end_len+1, one
// candidate per clock while enable is high.
//
// Optional build macro: GEN_COUNT_EN
//   defined   -> guess_count port and 48-bit saturating candidate counter
//   undefined -> neither exists; all other behaviour unchanged
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        one-cycle pulse, loads first candidate (IDLE/DONE only)
//   abort        return to IDLE from any state, wins over start
//   enable       advance permission, 0 holds the current candidate
//   start_len    first length, characters-1 (sampled at start)
//   end_len      last length, characters-1 (sampled at start)
//   guess        candidate, first character in [127:120], unused bytes zero
//   guesslen     candidate length-1
//   guess_valid  one-cycle strobe per distinct candidate
//   done         keyspace exhausted
//   guess_count  candidates emitted since start (GEN_COUNT_EN only)
//
// Handshake: guess/guesslen are meaningful only in a cycle where guess_valid
// is high; the block never waits on the consumer, enable is the only
// back-pressure and it simply freezes the odometer.
// ----------------------------------------------------------------------------
module md5_guess_generator #(
    parameter logic [7:0] CHARSET_LO = 8'h61,
    parameter logic [7:0] CHARSET_HI = 8'h7A
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic         enable,
    input  logic [3:0]   start_len,
    input  logic [3:0]   end_len,
    output logic [127:0] guess,
    output logic [3:0]   guesslen,
    output logic         guess_valid,
`ifdef GEN_COUNT_EN
    output logic         done,
    output logic [47:0]  guess_count
`else
    output logic         done
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [127:0]   r_guess, w_guess_nxt;
    logic [3:0]     r_guesslen, w_guesslen_nxt;
    logic           r_valid, w_valid_nxt;
    logic           r_done, w_done_nxt;
    logic [3:0]     r_end_len, w_end_len_nxt;

    // Odometer increment of the current candidate and the carry out of the
    // leftmost character.
    logic [127:0]   w_inc_guess;
    logic           w_carry;

`ifdef GEN_COUNT_EN
    logic [47:0]    r_count, w_count_nxt;
    logic [47:0]    w_count_inc;
`endif

    // Build n_chars copies of CHARSET_LO left-justified, zero elsewhere.
    function automatic logic [127:0] fill_lo(input logic [4:0] n_chars);
        logic [127:0] f;
        f = '0;
        for (int k = 0; k < 16; k++) begin
            if (k < int'(n_chars)) begin
                f[127-8*k -: 8] = CHARSET_LO;
            end
        end
        return f;
    endfunction

    // Carry enters at the rightmost active byte (index guesslen from the
    // left) and ripples leftwards; bytes past guesslen are never touched.
    always_comb begin
        w_inc_guess = r_guess;
        w_carry     = 1'b1;
        for (int k = 15; k >= 0; k--) begin
            if ((4'(k) <= r_guesslen) && w_carry) begin
                if (r_guess[127-8*k -: 8] == CHARSET_HI) begin
                    w_inc_guess[127-8*k -: 8] = CHARSET_LO;
                end else begin
                    w_inc_guess[127-8*k -: 8] = r_guess[127-8*k -: 8] + 8'd1;
                    w_carry                   = 1'b0;
                end
            end
        end
    end

`ifdef GEN_COUNT_EN
    assign w_count_inc = (r_count == '1) ? r_count : r_count + 48'd1;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_guess_nxt    = r_guess;
        w_guesslen_nxt = r_guesslen;
        w_valid_nxt    = 1'b0;
        w_done_nxt     = r_done;
        w_end_len_nxt  = r_end_len;
`ifdef GEN_COUNT_EN
        w_count_nxt    = r_count;
`endif
        if (abort) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        if (start_len <= end_len) begin
                            w_state_nxt    = ST_RUN;
                            w_guess_nxt    = fill_lo({1'b0, start_len} + 5'd1);
                            w_guesslen_nxt = start_len;
                            w_valid_nxt    = 1'b1;
                            w_done_nxt     = 1'b0;
                            w_end_len_nxt  = end_len;
`ifdef GEN_COUNT_EN
                            w_count_nxt    = 48'd1;
`endif
                        end else begin
                            // Empty keyspace: finish without a candidate.
                            w_state_nxt = ST_DONE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (enable) begin
                        if (!w_carry) begin
                            w_guess_nxt = w_inc_guess;
                            w_valid_nxt = 1'b1;
`ifdef GEN_COUNT_EN
                            w_count_nxt = w_count_inc;
`endif
                        end else if (r_guesslen < r_end_len) begin
                            // Length rollover: one more character, all LO.
                            w_guesslen_nxt = r_guesslen + 4'd1;
                            w_guess_nxt    = fill_lo({1'b0, r_guesslen} + 5'd2);
                            w_valid_nxt    = 1'b1;
`ifdef GEN_COUNT_EN
                            w_count_nxt    = w_count_inc;
`endif
                        end else begin
                            // Keyspace exhausted; guess keeps the last one.
                            w_state_nxt = ST_DONE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_guess    <= '0;
            r_guesslen <= '0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_end_len  <= '0;
`ifdef GEN_COUNT_EN
            r_count    <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_guess    <= w_guess_nxt;
            r_guesslen <= w_guesslen_nxt;
            r_valid    <= w_valid_nxt;
            r_done     <= w_done_nxt;
            r_end_len  <= w_end_len_nxt;
`ifdef GEN_COUNT_EN
            r_count    <= w_count_nxt;
`endif
        end
    end

    assign guess       = r_guess;
    assign guesslen    = r_guesslen;
    assign guess_valid = r_valid;
    assign done        = r_done;
`ifdef GEN_COUNT_EN
    assign guess_count = r_count;
`endif

endmodule

// File: tb/tb_md5_guess_generator.sv
// ----------------------------------------------------------------------------
// tb_md5_guess_generator
//
// Self-checking bench for md5_guess_generator. The reference model treats a
// candidate as a (length, base-N integer) pair and renders it into bytes with
// plain division; the full expected candidate sequence of a run is queued up
// front and popped on every guess_valid the DUT produces.
// ----------------------------------------------------------------------------
module tb_md5_guess_generator;
  localparam logic [7:0] LO = 8'h61;
  localparam logic [7:0] HI = 8'h7A;
  localparam int         N  = 26;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic         enable;
  logic [3:0]   start_len;
  logic [3:0]   end_len;
  logic [127:0] guess;
  logic [3:0]   guesslen;
  logic         guess_valid;
  logic         done;
`ifdef GEN_COUNT_EN
  logic [47:0]  guess_count;
`endif

  md5_guess_generator #(
    .CHARSET_LO(LO),
    .CHARSET_HI(HI)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .enable     (enable),
    .start_len  (start_len),
    .end_len    (end_len),
    .guess      (guess),
    .guesslen   (guesslen),
    .guess_valid(guess_valid),
`ifdef GEN_COUNT_EN
    .done       (done),
    .guess_count(guess_count)
`else
    .done       (done)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  logic [131:0] exp_q[$];

  task automatic check(input string tag, input logic [131:0] obs, input logic [131:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint pow_n(input int k);
    longint p = 1;
    for (int i = 0; i < k; i++) p = p * N;
    return p;
  endfunction

  // {len-1, guess} for the v-th string (base-N, rightmost digit last).
  function automatic logic [131:0] model_word(input int len, input longint v);
    logic [127:0] g = '0;
    longint       r = v;
    for (int j = 0; j <= len; j++) begin
      g[127-8*(len-j) -: 8] = LO + 8'(r % N);
      r = r / N;
    end
    return {4'(len), g};
  endfunction

  function automatic void model_fill(input int sl, input int el);
    int     len = sl;
    longint v   = 0;
    exp_q.delete();
    forever begin
      exp_q.push_back(model_word(len, v));
      v++;
      if (v == pow_n(len + 1)) begin
        if (len == el) break;
        len++;
        v = 0;
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the start edge.
  task automatic pulse_start(input logic [3:0] sl, input logic [3:0] el);
    start     = 1'b1;
    start_len = sl;
    end_len   = el;
    @(negedge clk);
    start     = 1'b0;
    start_len = $urandom_range(0, 15);
    end_len   = $urandom_range(0, 15);
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  // Full run against the model. trig/follow: after observing trig the next
  // candidate must be follow. total_exp 0 means use the model's count.
  task automatic run_space(input logic [3:0] sl, input logic [3:0] el, input bit rand_en,
                           input int total_exp, input logic [131:0] first_exp,
                           input logic [131:0] trig, input logic [131:0] follow);
    int           n = 0;
    int           total;
    bit           prev_en = 1'b1;
    bit           en;
    bit           seen_trig = 1'b0;
    bit           finished = 1'b0;
    logic [127:0] prev_g;
    logic [131:0] last_exp;
    logic [131:0] cur;
    model_fill(int'(sl), int'(el));
    total    = (total_exp != 0) ? total_exp : exp_q.size();
    last_exp = exp_q[exp_q.size()-1];
    enable   = 1'b1;
    pulse_start(sl, el);
    prev_g = guess;
    for (int cyc = 0; cyc < 40000; cyc++) begin
      if (done) begin
        finished = 1'b1;
        break;
      end
      cur = {guesslen, guess};
      if (!prev_en) begin
        check("hold_valid", 132'(guess_valid), 132'(0));
        check("hold_guess", 132'(guess), 132'(prev_g));
      end
      if (guess_valid) begin
        n++;
        if (exp_q.size() == 0) begin
          check("extra_cand", cur, 132'(0) - 132'(1));
        end else begin
          check("cand", cur, exp_q.pop_front());
        end
        if (n == 1) check("first_cand", cur, first_exp);
        if (seen_trig) check("follow_cand", cur, follow);
        seen_trig = (cur == trig);
      end
      prev_g  = guess;
      en      = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      enable  = en;
      prev_en = en;
      @(negedge clk);
    end
    check("run_finished", 132'(finished), 132'(1));
    check("done_flag", 132'(done), 132'(1));
    check("valid_at_done", 132'(guess_valid), 132'(0));
    check("n_valid", 132'(n), 132'(total));
    check("queue_empty", 132'(exp_q.size()), 132'(0));
    check("final_cand", {guesslen, guess}, last_exp);
`ifdef GEN_COUNT_EN
    check("count", 132'(guess_count), 132'(total));
`endif
    @(negedge clk);
    check("done_sticky", 132'(done), 132'(1));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] held;
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    enable    = 1'b0;
    start_len = 4'd0;
    end_len   = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_guess", 132'(guess), 132'(0));
    check("rst_len", 132'(guesslen), 132'(0));
    check("rst_valid", 132'(guess_valid), 132'(0));
    check("rst_done", 132'(done), 132'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Single character a..z
    run_space(4'd0, 4'd0, 1'b0, 26, {4'd0, 8'h61, 120'd0},
              {4'd0, 8'h79, 120'd0}, {4'd0, 8'h7a, 120'd0});
    // One and two characters, random enable; z -> aa
    run_space(4'd0, 4'd1, 1'b1, 702, {4'd0, 8'h61, 120'd0},
              {4'd0, 8'h7a, 120'd0}, {4'd1, 16'h6161, 112'd0});
    // Three characters; azz -> baa
    run_space(4'd2, 4'd2, 1'b0, 17576, {4'd2, 24'h616161, 104'd0},
              {4'd2, 24'h617a7a, 104'd0}, {4'd2, 24'h626161, 104'd0});

    // Pause / ignored start / abort on a four-character run
    enable = 1'b1;
    pulse_start(4'd3, 4'd3);
    check("len4_first", {guesslen, guess}, {4'd3, 32'h61616161, 96'd0});
    check("len4_first_v", 132'(guess_valid), 132'(1));
    held   = guess;
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("pause_valid", 132'(guess_valid), 132'(0));
      check("pause_guess", 132'(guess), 132'(held));
    end
    enable = 1'b1;
    @(negedge clk);
    check("resume_cand", {guesslen, guess}, {4'd3, 32'h61616162, 96'd0});
    check("resume_valid", 132'(guess_valid), 132'(1));
    pulse_start(4'd0, 4'd0);
    check("start_in_run", {guesslen, guess}, {4'd3, 32'h61616163, 96'd0});
    pulse_abort();
    check("abort_valid", 132'(guess_valid), 132'(0));
    check("abort_done", 132'(done), 132'(0));
    check("abort_hold", {guesslen, guess}, {4'd3, 32'h61616163, 96'd0});
    @(negedge clk);
    check("idle_valid", 132'(guess_valid), 132'(0));

    // Restart after abort goes back to "a"
    run_space(4'd0, 4'd0, 1'b1, 26, {4'd0, 8'h61, 120'd0},
              {4'd0, 8'h61, 120'd0}, {4'd0, 8'h62, 120'd0});

    // Empty keyspace
    pulse_start(4'd4, 4'd2);
    check("empty_done", 132'(done), 132'(1));
    check("empty_valid", 132'(guess_valid), 132'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("empty_novalid", 132'(guess_valid), 132'(0));
      check("empty_done_hold", 132'(done), 132'(1));
    end
    pulse_abort();
    check("abort_clr_done", 132'(done), 132'(0));

    // Full 16-character length
    enable = 1'b1;
    pulse_start(4'd15, 4'd15);
    check("len16_first", {guesslen, guess}, model_word(15, 0));
    @(negedge clk);
    check("len16_second", {guesslen, guess}, model_word(15, 1));
    @(negedge clk);
    check("len16_third", {guesslen, guess}, model_word(15, 2));

    // Asynchronous reset mid-run
    #2 rst_n = 1'b0;
    #1;
    check("arst_guess", 132'(guess), 132'(0));
    check("arst_len", 132'(guesslen), 132'(0));
    check("arst_valid", 132'(guess_valid), 132'(0));
    check("arst_done", 132'(done), 132'(0));
`ifdef GEN_COUNT_EN
    check("arst_count", 132'(guess_count), 132'(0));
`endif
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_valid", 132'(guess_valid), 132'(0));
    end

    // Random small keyspaces
    for (int r = 0; r < 3; r++) begin
      int sl;
      int el;
      sl = $urandom_range(0, 1);
      el = $urandom_range(sl, 1);
      run_space(4'(sl), 4'(el), 1'b1, 0, model_word(sl, 0),
                model_word(sl, 0), model_word(sl, 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
